// File: rtl/pc_ras_if.sv
//------------------------------------------------------------------------------
// Module      : pc_ras_if
// Description : Fetch-side bus of the PC / return-address-stack unit.
//               master : fetch controller (drives IF, pc_cmd, pc_v)
//               slave  : pc_ras (drives i_address and the RAS status flags)
//               Signals:
//                 IF            fetch enable
//                 pc_cmd[2:0]   next-PC command
//                 pc_v          absolute target or signed relative offset
//                 i_address     current fetch address
//                 ras_count     number of valid RAS entries
//                 ras_empty     RAS holds no entries
//                 ras_full      RAS holds RAS_DEPTH entries
//                 ras_overflow  sticky: a push happened while full
//                 ras_underflow one-cycle pulse: pop attempted while empty
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pc_ras_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    logic                               IF;
    logic [2:0]                         pc_cmd;
    logic [XLEN-1:0]                    pc_v;
    logic [XLEN-1:0]                    i_address;
    logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count;
    logic                               ras_empty;
    logic                               ras_full;
    logic                               ras_overflow;
    logic                               ras_underflow;

    modport master (
        output IF, pc_cmd, pc_v,
        input  i_address, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
    );

    modport slave (
        input  IF, pc_cmd, pc_v,
        output i_address, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
    );
endinterface

`default_nettype wire

// File: rtl/pc_ras.sv
//------------------------------------------------------------------------------
// Module      : pc_ras
// Description : Parametrised DLX fetch program counter with a circular
//               return-address stack. One command per enabled clock edge;
//               the resulting address appears on i_address one cycle later.
//               Ports:
//                 clk      system clock, rising edge
//                 reset_n  asynchronous active-low reset
//                 bus      pc_ras_if slave modport (command in, PC/RAS out)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_ras #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int              INSTR_BYTES = 4,
    parameter int              RAS_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    pc_ras_if.slave     bus
);

    localparam int              c_PTR_W      = $clog2(RAS_DEPTH);
    localparam int              c_CNT_W      = $clog2(RAS_DEPTH + 1);
    localparam logic [XLEN-1:0] c_ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(RAS_DEPTH);

    localparam logic [2:0] c_CMD_SEQ    = 3'b000;
    localparam logic [2:0] c_CMD_HOLD   = 3'b001;
    localparam logic [2:0] c_CMD_JUMP   = 3'b010;
    localparam logic [2:0] c_CMD_BRANCH = 3'b011;
    localparam logic [2:0] c_CMD_CALL   = 3'b100;
    localparam logic [2:0] c_CMD_RET    = 3'b101;
    localparam logic [2:0] c_CMD_CALLR  = 3'b110;

    logic [XLEN-1:0]    r_pc;
    logic [c_PTR_W-1:0] r_tp;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ovf;
    logic               r_unf;
    logic [XLEN-1:0]    r_mem [RAS_DEPTH];

    logic [XLEN-1:0]    w_seq;
    logic [XLEN-1:0]    w_top;
    logic [XLEN-1:0]    w_next;
    logic [XLEN-1:0]    w_target;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;

    assign w_seq    = r_pc + XLEN'(INSTR_BYTES);
    assign w_top    = r_mem[r_tp - c_PTR_W'(1)];
    assign w_empty  = (r_cnt == '0);
    assign w_full   = (r_cnt == c_CNT_FULL);
    // Every path goes through the mask; seq/hold/popped values are already
    // aligned, so only pc_v-derived targets are actually affected.
    assign w_target = w_next & c_ALIGN_MASK;

    always_comb begin
        w_next = w_seq;
        w_push = 1'b0;
        w_pop  = 1'b0;
        case (bus.pc_cmd)
            c_CMD_SEQ:    w_next = w_seq;
            c_CMD_HOLD:   w_next = r_pc;
            c_CMD_JUMP:   w_next = bus.pc_v;
            c_CMD_BRANCH: w_next = r_pc + bus.pc_v;
            c_CMD_CALL: begin
                w_next = bus.pc_v;
                w_push = 1'b1;
            end
            c_CMD_RET: begin
                w_pop  = 1'b1;
                w_next = w_empty ? w_seq : w_top;
            end
            c_CMD_CALLR: begin
                w_next = r_pc + bus.pc_v;
                w_push = 1'b1;
            end
            default:      w_next = w_seq;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc  <= RESET_VEC;
            r_tp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_unf <= 1'b0;
            if (bus.IF) begin
                r_pc <= w_target;
                if (w_push) begin
                    // Pointer width equals log2(RAS_DEPTH), so +1 wraps for
                    // free; a push while full silently recycles the oldest slot.
                    r_tp <= r_tp + c_PTR_W'(1);
                    if (w_full) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end else if (w_pop) begin
                    if (w_empty) begin
                        r_unf <= 1'b1;
                    end else begin
                        r_tp  <= r_tp - c_PTR_W'(1);
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
            end
        end
    end

    // Storage needs no reset; validity is tracked by r_cnt alone.
    always_ff @(posedge clk) begin
        if (bus.IF && w_push) begin
            r_mem[r_tp] <= w_seq;
        end
    end

    assign bus.i_address     = r_pc;
    assign bus.ras_count     = r_cnt;
    assign bus.ras_empty     = w_empty;
    assign bus.ras_full      = w_full;
    assign bus.ras_overflow  = r_ovf;
    assign bus.ras_underflow = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_pc_ras.sv
//------------------------------------------------------------------------------
// Module      : tb_pc_ras
// Description : Self-checking bench for pc_ras (XLEN=32, RESET_VEC=0,
//               INSTR_BYTES=4, RAS_DEPTH=4): directed vector table,
//               hand-written overflow / async-reset sequences, and a
//               randomized run against a queue-based reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_ras;

    localparam int c_XLEN  = 32;
    localparam int c_DEPTH = 4;

    typedef struct {
        logic        en;
        logic [2:0]  cmd;
        logic [31:0] v;
        logic [31:0] pc;
        int          cnt;
        logic        unf;
        logic        ovf;
    } vec_t;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    pc_ras_if #(.XLEN(c_XLEN), .RAS_DEPTH(c_DEPTH)) bus ();

    pc_ras #(
        .XLEN        (c_XLEN),
        .RESET_VEC   (32'h0),
        .INSTR_BYTES (4),
        .RAS_DEPTH   (c_DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: the RAS is simply a bounded list of return addresses.
    logic [31:0] m_pc;
    logic [31:0] m_stk[$];
    logic        m_ovf;
    logic        m_unf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input int cnt,
                           input logic unf, input logic ovf);
        chk({tag, " i_address"},     bus.i_address, pc);
        chk({tag, " ras_count"},     32'(bus.ras_count), 32'(cnt));
        chk({tag, " ras_empty"},     32'(bus.ras_empty), 32'(cnt == 0));
        chk({tag, " ras_full"},      32'(bus.ras_full), 32'(cnt == c_DEPTH));
        chk({tag, " ras_underflow"}, 32'(bus.ras_underflow), 32'(unf));
        chk({tag, " ras_overflow"},  32'(bus.ras_overflow), 32'(ovf));
    endtask

    // Drive a command just after an edge, then sample 1 ns after the next edge.
    task automatic step(input logic en, input logic [2:0] cmd, input logic [31:0] v);
        bus.IF     = en;
        bus.pc_cmd = cmd;
        bus.pc_v   = v;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic en, input logic [2:0] cmd, input logic [31:0] v);
        logic [31:0] seq;
        logic [31:0] nxt;
        seq   = m_pc + 32'd4;
        m_unf = 1'b0;
        if (en) begin
            nxt = seq;
            case (cmd)
                3'd1: nxt = m_pc;
                3'd2: nxt = v;
                3'd3: nxt = m_pc + v;
                3'd4, 3'd6: begin
                    nxt = (cmd == 3'd4) ? v : m_pc + v;
                    m_stk.push_back(seq);
                    if (m_stk.size() > c_DEPTH) begin
                        void'(m_stk.pop_front());
                        m_ovf = 1'b1;
                    end
                end
                3'd5: begin
                    if (m_stk.size() > 0) nxt = m_stk.pop_back();
                    else m_unf = 1'b1;
                end
                default: nxt = seq;
            endcase
            m_pc = nxt & ~32'h3;
        end
    endtask

    vec_t tbl[$];

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset_n    = 1'b0;
        bus.IF     = 1'b0;
        bus.pc_cmd = 3'd0;
        bus.pc_v   = 32'h0;

        //             en    cmd   pc_v           i_address     cnt unf   ovf
        tbl.push_back('{1'b0, 3'd0, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 3'd2, 32'h0000_0500, 32'h0000_0000, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd0, 32'h0000_0000, 32'h0000_0004, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd0, 32'h0000_0000, 32'h0000_0008, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd0, 32'h0000_0000, 32'h0000_000C, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd1, 32'h0000_0000, 32'h0000_000C, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd1, 32'h0000_0000, 32'h0000_000C, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd2, 32'h0000_0103, 32'h0000_0100, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd3, 32'hFFFF_FFF0, 32'h0000_00F0, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd3, 32'h0000_0020, 32'h0000_0110, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd2, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd0, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd7, 32'h0000_0800, 32'h0000_0004, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd2, 32'h0000_0100, 32'h0000_0100, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd4, 32'h0000_0400, 32'h0000_0400, 1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd0, 32'h0000_0000, 32'h0000_0404, 1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd6, 32'h0000_0010, 32'h0000_0414, 2, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd5, 32'h0000_0000, 32'h0000_0408, 1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd5, 32'h0000_0000, 32'h0000_0104, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd2, 32'h0000_0200, 32'h0000_0200, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd5, 32'h0000_0000, 32'h0000_0204, 0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 3'd1, 32'h0000_0000, 32'h0000_0204, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 3'd5, 32'h0000_0000, 32'h0000_0204, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd3, 32'h0000_0007, 32'h0000_0208, 0, 1'b0, 1'b0});

        // Reset state, with clocks running under reset.
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 32'h0, 0, 1'b0, 1'b0);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].cmd, tbl[i].v);
            chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].cnt, tbl[i].unf, tbl[i].ovf);
        end

        // Overflow: five nested calls, four returns newest first, then underflow.
        step(1'b1, 3'd2, 32'h0);
        chk("ovf start", bus.i_address, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 3'd4, 32'(k * 16 + 16));
            chk_all($sformatf("ovf call%0d", k), 32'(k * 16 + 16),
                    (k < 4) ? k + 1 : 4, 1'b0, (k == 4));
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 3'd5, 32'h0);
            chk_all($sformatf("ovf ret%0d", k), 32'(32'h44 - k * 16), 3 - k, 1'b0, 1'b1);
        end
        step(1'b1, 3'd5, 32'h0);
        chk_all("ovf ret underflow", 32'h18, 0, 1'b1, 1'b1);
        step(1'b1, 3'd1, 32'h0);
        chk_all("ovf pulse end", 32'h18, 0, 1'b0, 1'b1);

        // Async reset between edges right after a CALL.
        step(1'b1, 3'd4, 32'h0000_0900);
        chk_all("pre-reset call", 32'h900, 1, 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("async reset", 32'h0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("reset held", bus.i_address, 32'h0);
        reset_n = 1'b1;
        step(1'b1, 3'd0, 32'h0);
        chk_all("post-reset seq", 32'h4, 0, 1'b0, 1'b0);

        // Randomized run against the reference model, from a fresh reset.
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        m_pc  = 32'h0;
        m_stk = {};
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic        en;
            logic [2:0]  cmd;
            logic [31:0] v;
            en  = ($urandom_range(0, 7) != 0);
            cmd = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) v = $urandom;
            else v = 32'($signed($urandom_range(0, 511)) - 256);
            model_step(en, cmd, v);
            step(en, cmd, v);
            chk_all($sformatf("rand%0d", n), m_pc, m_stk.size(), m_unf, m_ovf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
